regfile_access_master: RTL and testbench

- Command-side initiator for the 8x16 register file. Converts a valid/ready command stream (read or write, address, data) into single-cycle WrEn/RdEn pulses on the register-file port.
- Captures RdData at the correct cycle and returns one response per command over a valid/ready response channel.
- Sits between a bus/CPU-side requester and the register file. It enforces one-operation-at-a-time and checks address range.

---
 rtl/regfile_access_master.sv | 134 +++++++++++++
 tb/tb_regfile_access_master.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_master.sv
// Command-side initiator for the register file: turns valid/ready commands into
// single-cycle WrEn/RdEn pulses and returns one response per command.
module regfile_access_master #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              WrEn,
    output logic              RdEn,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] WrData,
    input  logic [DATA_W-1:0] RdData
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    // One extra bit so DEPTH == 2**ADDR_W would still compare correctly.
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [1:0]        state_q, state_d;
    logic              wr_en_q, wr_en_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              addr_ok;

    assign addr_ok   = ({1'b0, cmd_addr} < DEPTH_C);
    assign cmd_ready = (state_q == S_IDLE);

    always_comb begin
        state_d     = state_q;
        wr_en_d     = wr_en_q;
        rd_en_d     = rd_en_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    if (addr_ok) begin
                        wr_en_d = cmd_write;
                        rd_en_d = ~cmd_write;
                        state_d = S_ISSUE;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                        state_d     = S_RESP;
                    end
                end
            end
            S_ISSUE: begin
                // The file samples the enable at this edge, so it drops here.
                wr_en_d = 1'b0;
                rd_en_d = 1'b0;
                if (wr_en_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    state_d     = S_RESP;
                end else begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = RdData;
                rsp_err_d   = 1'b0;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign WrEn      = wr_en_q;
    assign RdEn      = rd_en_q;
    assign Address   = addr_q;
    assign WrData    = wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_regfile_access_master.sv
// Bench for regfile_access_master: an attached 8x16 register file plus a
// shadow-memory reference model of what every command should return.
module tb_regfile_access_master;

    logic        CLK = 1'b0;
    logic        RST;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [3:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [15:0] rsp_rdata;
    logic        WrEn, RdEn;
    logic [3:0]  Address;
    logic [15:0] WrData, RdData;

    int n_checks = 0;
    int n_errors = 0;
    int n_txn    = 0;

    int wr_cycles = 0;
    int rd_cycles = 0;
    int both_hi   = 0;

    logic [15:0] rf_mem  [0:7] = '{default: 16'h0};
    logic [15:0] ref_mem [0:7] = '{default: 16'h0};
    logic [15:0] rd_data_q = 16'h0;

    regfile_access_master #(.DATA_W(16), .ADDR_W(4), .DEPTH(8)) dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
        .RdData(RdData)
    );

    always #5 CLK = ~CLK;

    // Register file: registered read, data present only the cycle after RdEn.
    always @(posedge CLK) begin
        if (WrEn && !Address[3]) rf_mem[Address[2:0]] <= WrData;
        rd_data_q <= (RdEn && !Address[3]) ? rf_mem[Address[2:0]] : 16'h0;
    end
    assign RdData = rd_data_q;

    always @(posedge CLK) begin
        if (WrEn) wr_cycles++;
        if (RdEn) rd_cycles++;
        if (WrEn && RdEn) both_hi++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one command starting just after an edge and follows it to the
    // response handshake, holding rsp_ready low for 'delay' cycles.
    task automatic do_cmd(input logic wr, input logic [3:0] addr, input logic [15:0] data,
                          input int delay);
        logic        in_range;
        logic [15:0] exp_rdata;
        int          exp_lat, lat, wr0, rd0;
        in_range  = (addr < 4'd8);
        exp_rdata = (!wr && in_range) ? ref_mem[addr[2:0]] : 16'h0;
        exp_lat   = !in_range ? 0 : (wr ? 1 : 2);
        wr0 = wr_cycles;
        rd0 = rd_cycles;

        check("idle_ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        rsp_ready = (delay == 0);
        @(posedge CLK); #1;
        check("accepted", cmd_ready, 1'b0);
        check("addr_latch", Address, addr);
        check("wdata_latch", WrData, data);
        check("wren_issue", WrEn, wr && in_range);
        check("rden_issue", RdEn, !wr && in_range);
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = 4'($urandom);
        cmd_wdata = 16'($urandom);

        lat = 0;
        while (!rsp_valid && lat < 8) begin
            @(posedge CLK); #1;
            lat++;
        end
        check("latency", lat, exp_lat);
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_err", rsp_err, !in_range);

        for (int i = 0; i < delay; i++) begin
            cmd_valid = 1'($urandom);
            @(posedge CLK); #1;
            check("hold_valid", rsp_valid, 1'b1);
            check("hold_rdata", rsp_rdata, exp_rdata);
            check("hold_err", rsp_err, !in_range);
            check("hold_busy", cmd_ready, 1'b0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge CLK); #1;
        check("rsp_done", rsp_valid, 1'b0);
        check("rsp_clr", {rsp_err, rsp_rdata}, 17'h0);
        check("back_idle", cmd_ready, 1'b1);
        check("addr_hold", Address, addr);
        check("wr_pulses", wr_cycles - wr0, (wr && in_range) ? 1 : 0);
        check("rd_pulses", rd_cycles - rd0, (!wr && in_range) ? 1 : 0);
        rsp_ready = 1'b0;

        if (wr && in_range) ref_mem[addr[2:0]] = data;
        n_txn++;
        $display("txn %0d: %s addr=%0d data=0x%04h delay=%0d -> lat=%0d rdata=0x%04h err=%0d",
                 n_txn, wr ? "WR" : "RD", addr, data, delay, lat, exp_rdata, !in_range);
    endtask

    initial begin
        RST       = 1'b0;
        cmd_valid = 1'($urandom);
        cmd_write = 1'($urandom);
        cmd_addr  = 4'($urandom);
        cmd_wdata = 16'($urandom);
        rsp_ready = 1'($urandom);
        #1;
        check("rst_wren", WrEn, 1'b0);
        check("rst_rden", RdEn, 1'b0);
        check("rst_valid", rsp_valid, 1'b0);
        check("rst_addr_data", {Address, WrData, rsp_rdata, rsp_err}, 37'h0);
        check("rst_ready", cmd_ready, 1'b1);
        @(posedge CLK); #1;
        check("rst_hold_valid", rsp_valid, 1'b0);
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        #2 RST = 1'b1;
        @(posedge CLK); #1;
        check("post_rst_ready", cmd_ready, 1'b1);
        check("post_rst_valid", rsp_valid, 1'b0);

        do_cmd(1'b1, 4'd3, 16'hA5A5, 0);
        do_cmd(1'b0, 4'd3, 16'h0000, 0);
        do_cmd(1'b1, 4'd7, 16'h1234, 0);
        do_cmd(1'b0, 4'd7, 16'h0000, 0);
        do_cmd(1'b0, 4'd8, 16'h0000, 0);
        do_cmd(1'b1, 4'd15, 16'hFFFF, 0);
        do_cmd(1'b0, 4'd0, 16'h0000, 0);
        do_cmd(1'b0, 4'd3, 16'h0000, 5);
        do_cmd(1'b1, 4'd0, 16'h0F0F, 0);
        do_cmd(1'b1, 4'd2, 16'h0000, 0);

        // Abort a write to addr 2 while its WrEn is still up.
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 4'd2;
        cmd_wdata = 16'hBEEF;
        @(posedge CLK); #1;
        check("abort_wren_up", WrEn, 1'b1);
        #2 RST = 1'b0;
        #1;
        check("abort_wren_drop", WrEn, 1'b0);
        check("abort_no_rsp", rsp_valid, 1'b0);
        check("abort_idle", cmd_ready, 1'b1);
        check("abort_addr", Address, 4'd0);
        cmd_valid = 1'b0;
        @(posedge CLK); #3;
        RST = 1'b1;
        @(posedge CLK); #1;
        check("abort_still_quiet", rsp_valid, 1'b0);
        do_cmd(1'b0, 4'd2, 16'h0000, 0);

        for (int t = 0; t < 40; t++)
            do_cmd(1'($urandom), 4'($urandom), 16'($urandom), int'($urandom_range(0, 3)));

        check("enables_exclusive", both_hi, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
